// File: rtl/mips_muldiv_alu.sv
// Execute-stage ALU: single-cycle logic/compare/shift ops plus an iterative unsigned MULTU/DIVU
// unit with HI/LO. Define ALU_OVF_EN to enable signed-overflow detection on ADD and SUBU.
module mips_muldiv_alu #(
   parameter int W   = 32,
   parameter int SHW = $clog2(W)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [3:0]   ctrl,
   input  logic [W-1:0] arg1,
   input  logic [W-1:0] arg2,
   output logic         out_valid,
   output logic [W-1:0] result,
   output logic         eq,
   output logic         busy,
   output logic         div_by_zero,
   output logic         ovf
);
   localparam int CW = $clog2(W + 1);

   // Handshake: an op is accepted on a rising edge where in_valid & in_ready; in_ready is high
   // only in IDLE (including the cycle out_valid pulses). out_valid is a one-cycle pulse with no
   // backpressure, and result/eq/div_by_zero/ovf are meaningful only while it is high.
   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic [W-1:0]   result_q, result_d;
   logic [W-1:0]   wk_hi_q, wk_hi_d, wk_lo_q, wk_lo_d, opb_q, opb_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           out_valid_q, out_valid_d, eq_q, eq_d, dbz_q, dbz_d;
`ifdef ALU_OVF_EN
   logic           ovf_q, ovf_d;
`endif

   logic           accept;
   logic [SHW-1:0] shamt;
   logic [W-1:0]   sum, diff, alu_res;
   logic [W:0]     mul_sum, div_sh;
   logic [W-1:0]   mul_hi, mul_lo, div_hi, div_lo;
   logic           div_ge;

   assign accept = in_valid && (state_q == IDLE);
   assign shamt  = arg2[SHW-1:0];
   assign sum    = arg1 + arg2;
   assign diff   = arg1 - arg2;

   // Shift-add step: {wk_hi, wk_lo} holds {partial product, remaining multiplier bits}.
   assign mul_sum = {1'b0, wk_hi_q} + {1'b0, (wk_lo_q[0] ? opb_q : {W{1'b0}})};
   assign mul_hi  = mul_sum[W:1];
   assign mul_lo  = {mul_sum[0], wk_lo_q[W-1:1]};

   // Restoring step: {wk_hi, wk_lo} holds {partial remainder, dividend bits / quotient bits}.
   assign div_sh  = {wk_hi_q, wk_lo_q[W-1]};
   assign div_ge  = (div_sh >= {1'b0, opb_q});
   assign div_hi  = div_ge ? (div_sh[W-1:0] - opb_q) : div_sh[W-1:0];
   assign div_lo  = {wk_lo_q[W-2:0], div_ge};

   always_comb begin
      alu_res = '0;
      case (ctrl)
         4'h0:    alu_res = sum;
         4'h1:    alu_res = diff;
         4'h2:    alu_res = arg1 & arg2;
         4'h3:    alu_res = arg1 | arg2;
         4'h4:    alu_res = arg1 ^ arg2;
         4'h5:    alu_res = ~(arg1 | arg2);
         4'h6:    alu_res = {{(W-1){1'b0}}, ($signed(arg1) < $signed(arg2))};
         4'h7:    alu_res = {{(W-1){1'b0}}, (arg1 < arg2)};
         4'h8:    alu_res = arg1 << shamt;
         4'h9:    alu_res = arg1 >> shamt;
         4'hA:    alu_res = $unsigned($signed(arg1) >>> shamt);
         4'hD:    alu_res = hi_q;
         4'hE:    alu_res = lo_q;
         4'hF:    alu_res = sum;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      result_d    = result_q;
      wk_hi_d     = wk_hi_q;
      wk_lo_d     = wk_lo_q;
      opb_d       = opb_q;
      cnt_d       = cnt_q;
      eq_d        = eq_q;
      out_valid_d = 1'b0;
      dbz_d       = 1'b0;
`ifdef ALU_OVF_EN
      ovf_d       = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               eq_d = (arg1 == arg2);
               if (ctrl == 4'hB || (ctrl == 4'hC && arg2 != '0)) begin
                  state_d = (ctrl == 4'hB) ? MUL : DIV;
                  wk_hi_d = '0;
                  wk_lo_d = arg1;
                  opb_d   = arg2;
                  cnt_d   = CW'(W);
               end else if (ctrl == 4'hC) begin
                  hi_d        = arg1;
                  lo_d        = '1;
                  result_d    = '1;
                  out_valid_d = 1'b1;
                  dbz_d       = 1'b1;
               end else begin
                  result_d    = alu_res;
                  out_valid_d = 1'b1;
`ifdef ALU_OVF_EN
                  if (ctrl == 4'hF)
                     ovf_d = (arg1[W-1] == arg2[W-1]) && (sum[W-1] != arg1[W-1]);
                  else if (ctrl == 4'h1)
                     ovf_d = (arg1[W-1] != arg2[W-1]) && (diff[W-1] != arg1[W-1]);
`endif
               end
            end
         end
         MUL, DIV: begin
            wk_hi_d = (state_q == MUL) ? mul_hi : div_hi;
            wk_lo_d = (state_q == MUL) ? mul_lo : div_lo;
            cnt_d   = cnt_q - CW'(1);
            // The last iteration writes HI/LO directly so completion costs no extra cycle.
            if (cnt_q == CW'(1)) begin
               hi_d        = wk_hi_d;
               lo_d        = wk_lo_d;
               result_d    = wk_lo_d;
               out_valid_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         hi_q        <= '0;
         lo_q        <= '0;
         result_q    <= '0;
         wk_hi_q     <= '0;
         wk_lo_q     <= '0;
         opb_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         eq_q        <= 1'b0;
         dbz_q       <= 1'b0;
`ifdef ALU_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         result_q    <= result_d;
         wk_hi_q     <= wk_hi_d;
         wk_lo_q     <= wk_lo_d;
         opb_q       <= opb_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         eq_q        <= eq_d;
         dbz_q       <= dbz_d;
`ifdef ALU_OVF_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign out_valid   = out_valid_q;
   assign result      = result_q;
   assign eq          = eq_q;
   assign div_by_zero = dbz_q;
`ifdef ALU_OVF_EN
   assign ovf         = ovf_q;
`else
   assign ovf         = 1'b0;
`endif

endmodule

// File: tb/tb_mips_muldiv_alu.sv
// Self-checking bench for mips_muldiv_alu: arithmetic reference model with a timed expected queue,
// plus literal pins on selected results.
module tb_mips_muldiv_alu;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   ctrl;
   logic [W-1:0] arg1, arg2;
   logic         out_valid;
   logic [W-1:0] result;
   logic         eq, busy, div_by_zero, ovf;

   mips_muldiv_alu #(.W(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ctrl(ctrl),
      .arg1(arg1), .arg2(arg2), .out_valid(out_valid), .result(result), .eq(eq),
      .busy(busy), .div_by_zero(div_by_zero), .ovf(ovf)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   // ---------------- model / scoreboard ----------------
   typedef struct {
      logic [W-1:0] res;
      logic         eq;
      logic         dbz;
      logic         ovf;
      int           due;
   } exp_t;

   exp_t         exp_q[$];
   exp_t         got_e;
   logic [W-1:0] m_hi = '0, m_lo = '0;
   int           busy_end = 0;
   int           checks = 0, errors = 0;
   logic [W-1:0] last_res = '0;
   logic         last_ovf = 1'b0;
   logic         started = 1'b0;
`ifdef ALU_OVF_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cyc %0d)", name, act, req, cyc);
      end
   endtask

   task automatic model_accept(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t        e;
      int          lat;
      logic [63:0] p;
      longint      s;
      logic [4:0]  sh;
      sh    = b[4:0];
      e.eq  = (a == b);
      e.dbz = 1'b0;
      e.ovf = 1'b0;
      e.res = '0;
      lat   = 1;
      case (c)
         4'h0, 4'hF: e.res = a + b;
         4'h1:       e.res = a - b;
         4'h2:       e.res = a & b;
         4'h3:       e.res = a | b;
         4'h4:       e.res = a ^ b;
         4'h5:       e.res = ~(a | b);
         4'h6:       e.res = ($signed(a) < $signed(b)) ? 1 : 0;
         4'h7:       e.res = (a < b) ? 1 : 0;
         4'h8:       e.res = a << sh;
         4'h9:       e.res = a >> sh;
         4'hA:       e.res = $signed(a) >>> sh;
         4'hB: begin
            p = {32'h0, a} * {32'h0, b};
            m_hi = p[63:32]; m_lo = p[31:0]; e.res = m_lo; lat = W + 1;
         end
         4'hC: begin
            if (b == 0) begin
               m_hi = a; m_lo = '1; e.res = m_lo; e.dbz = 1'b1;
            end else begin
               m_lo = a / b; m_hi = a % b; e.res = m_lo; lat = W + 1;
            end
         end
         4'hD:       e.res = m_hi;
         default:    e.res = m_lo;
      endcase
      if (c == 4'hF) s = longint'($signed(a)) + longint'($signed(b));
      else           s = longint'($signed(a)) - longint'($signed(b));
      if (OVF_ON && (c == 4'hF || c == 4'h1))
         e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      e.due = cyc + lat - 1;
      if (lat > 1) busy_end = cyc + W;
      exp_q.push_back(e);
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (started && !rst) begin
         check("in_ready", {31'b0, in_ready}, {31'b0, (cyc >= busy_end)});
         check("busy", {31'b0, busy}, {31'b0, (cyc < busy_end)});
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL spurious_out_valid: got result %h, expected no output (cyc %0d)", result, cyc);
            end else begin
               got_e = exp_q.pop_front();
               check("out_valid_cycle", cyc, got_e.due);
               check("result", result, got_e.res);
               check("eq", {31'b0, eq}, {31'b0, got_e.eq});
               check("div_by_zero", {31'b0, div_by_zero}, {31'b0, got_e.dbz});
               check("ovf", {31'b0, ovf}, {31'b0, got_e.ovf});
               last_res = result;
               last_ovf = ovf;
            end
         end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            got_e = exp_q.pop_front();
            checks++; errors++;
            $display("FAIL missing_out_valid: got none, expected result %h at cyc %0d", got_e.res, got_e.due);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
      logic ok;
      ok = 1'b0;
      ctrl = c; arg1 = a; arg2 = b; in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (in_ready) begin
            @(posedge clk); #1;
            model_accept(c, a, b);
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      arg1 = $urandom; arg2 = $urandom; ctrl = 4'($urandom_range(0, 15));
      if (!ok) begin
         checks++; errors++;
         $display("FAIL accept_timeout: got in_ready=0, expected acceptance of ctrl %h", c);
      end
      @(negedge clk);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100; i++) begin
         #1;
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      if (exp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL result_timeout: got %0d pending, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic pin(input string name, input logic [3:0] c, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] lit);
      do_op(c, a, b);
      wait_idle();
      check(name, last_res, lit);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; in_valid = 1'b0; ctrl = 4'h0; arg1 = '0; arg2 = '0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_eq", {31'b0, eq}, 32'd0);
      check("rst_dbz", {31'b0, div_by_zero}, 32'd0);
      check("rst_ovf", {31'b0, ovf}, 32'd0);
      rst = 1'b0;
      started = 1'b1;
      @(negedge clk);

      pin("addu_wrap",  4'h0, 32'hFFFFFFFF, 32'h1, 32'h0);
      pin("sra",        4'hA, 32'h80000000, 32'h4, 32'hF8000000);
      pin("slt",        4'h6, 32'hFFFFFFFF, 32'h1, 32'h1);
      pin("sltu",       4'h7, 32'hFFFFFFFF, 32'h1, 32'h0);
      pin("subu",       4'h1, 32'h5, 32'h7, 32'hFFFFFFFE);
      pin("and",        4'h2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
      pin("or",         4'h3, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0);
      pin("xor",        4'h4, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0);
      pin("nor",        4'h5, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0);
      pin("sll31",      4'h8, 32'h1, 32'd31, 32'h80000000);
      pin("sll_hibits", 4'h8, 32'h1, 32'h25, 32'h20);
      pin("srl31",      4'h9, 32'h80000000, 32'h3F, 32'h1);
      pin("addu_eq",    4'h0, 32'h12345678, 32'h12345678, 32'h2468ACF0);

      pin("multu_lo",   4'hB, 32'h00010000, 32'h00010000, 32'h0);
      pin("mfhi_mul",   4'hD, 32'h0, 32'h0, 32'h1);
      pin("mflo_mul",   4'hE, 32'h0, 32'h0, 32'h0);
      pin("multu_max",  4'hB, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1);
      pin("mfhi_max",   4'hD, 32'h0, 32'h0, 32'hFFFFFFFE);
      pin("divu_100_7", 4'hC, 32'd100, 32'd7, 32'd14);
      pin("mfhi_div",   4'hD, 32'h0, 32'h0, 32'd2);
      pin("divu_big",   4'hC, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF);
      pin("mfhi_big",   4'hD, 32'h0, 32'h0, 32'hF);
      pin("divu_eq",    4'hC, 32'd7, 32'd7, 32'd1);
      pin("divu_small", 4'hC, 32'd3, 32'd9, 32'd0);
      pin("mfhi_small", 4'hD, 32'h0, 32'h0, 32'd3);
      pin("divu_zero",  4'hC, 32'd5, 32'd0, 32'hFFFFFFFF);
      pin("mfhi_dz",    4'hD, 32'h0, 32'h0, 32'd5);
      pin("mflo_dz",    4'hE, 32'h0, 32'h0, 32'hFFFFFFFF);

      // Next op is held valid while the multiply runs and lands in the out_valid cycle.
      do_op(4'hB, 32'd3, 32'd5);
      do_op(4'h0, 32'd1, 32'd2);
      wait_idle();
      check("back_to_back", last_res, 32'd3);
      pin("mflo_b2b",   4'hE, 32'h0, 32'h0, 32'd15);

      pin("add_ovf",    4'hF, 32'h7FFFFFFF, 32'h1, 32'h80000000);
      check("add_ovf_flag", {31'b0, last_ovf}, {31'b0, OVF_ON});
      pin("add_small",  4'hF, 32'd1, 32'd2, 32'd3);
      pin("sub_ovf",    4'h1, 32'h80000000, 32'h1, 32'h7FFFFFFF);
      check("sub_ovf_flag", {31'b0, last_ovf}, {31'b0, OVF_ON});

      do_op(4'hB, 32'h1234, 32'h5678);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      exp_q.delete(); busy_end = 0; m_hi = '0; m_lo = '0;
      #1;
      check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
      check("midrst_busy", {31'b0, busy}, 32'd0);
      check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      check("midrst_result", result, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      pin("mflo_rst",   4'hE, 32'h0, 32'h0, 32'h0);
      pin("mfhi_rst",   4'hD, 32'h0, 32'h0, 32'h0);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
